// File: rtl/sync_fifo_pkg.sv
// Shared helpers for the level-reporting synchronous FIFO.
// Width derivations are done here so every file sizes its buses the same way.
package sync_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // The level must be able to hold DEPTH itself, not just DEPTH-1.
  function automatic int lvl_width(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

endpackage

// File: rtl/sync_fifo_lvl_if.sv
// Handshake, data, threshold and status bundle of sync_fifo_lvl.
// The slave modport is the FIFO side; the master modport is the user side.
interface sync_fifo_lvl_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 12
);
  localparam int LVL_WIDTH = lvl_width(DEPTH);

  logic                  flush_i;
  logic                  wr_en_i;
  logic [DATA_WIDTH-1:0] wdata_i;
  logic                  wfull_o;
  logic                  walmost_full_o;
  logic                  rd_en_i;
  logic [DATA_WIDTH-1:0] rdata_o;
  logic                  rempty_o;
  logic                  ralmost_empty_o;
  logic [LVL_WIDTH-1:0]  afull_thresh_i;
  logic [LVL_WIDTH-1:0]  aempty_thresh_i;
  logic [LVL_WIDTH-1:0]  level_o;
  logic                  overflow_o;
  logic                  underflow_o;
  logic                  clear_err_i;

  modport slave (
    input  flush_i, wr_en_i, wdata_i, rd_en_i,
           afull_thresh_i, aempty_thresh_i, clear_err_i,
    output wfull_o, walmost_full_o, rdata_o, rempty_o,
           ralmost_empty_o, level_o, overflow_o, underflow_o
  );

  modport master (
    output flush_i, wr_en_i, wdata_i, rd_en_i,
           afull_thresh_i, aempty_thresh_i, clear_err_i,
    input  wfull_o, walmost_full_o, rdata_o, rempty_o,
           ralmost_empty_o, level_o, overflow_o, underflow_o
  );

endinterface

// File: rtl/sync_fifo_wrap_ctr.sv
// Modulo-DEPTH address counter; wraps DEPTH-1 -> 0 so non-power-of-2 depths
// never alias onto unused memory rows.
module sync_fifo_wrap_ctr
  import sync_fifo_pkg::*;
#(
  parameter int DEPTH = 12,
  localparam int AW   = addr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk_i) begin
    if (reset_i || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= (count == LAST) ? '0 : count + AW'(1);
    end
  end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Single-clock show-ahead FIFO with arbitrary depth, exact fill level,
// programmable almost-full/almost-empty thresholds, flush and sticky error flags.
module sync_fifo_lvl
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 12,
  localparam int LVL_WIDTH = lvl_width(DEPTH),
  localparam int AW        = addr_width(DEPTH)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  sync_fifo_lvl_if.slave  fifo
);

  localparam logic [LVL_WIDTH-1:0] FULL_LVL = LVL_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_addr;
  logic [AW-1:0]         rd_addr;
  logic [LVL_WIDTH-1:0]  level;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_inc;
  logic                  rd_inc;

  // Status decodes from the level register only; no same-cycle bypass.
  always_comb begin
    full   = (level == FULL_LVL);
    empty  = (level == '0);
    wr_acc = fifo.wr_en_i && !full;
    rd_acc = fifo.rd_en_i && !empty;
    wr_inc = wr_acc && !fifo.flush_i;
    rd_inc = rd_acc && !fifo.flush_i;
  end

  sync_fifo_wrap_ctr #(.DEPTH(DEPTH)) u_wr_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (fifo.flush_i),
    .inc     (wr_inc),
    .count   (wr_addr)
  );

  sync_fifo_wrap_ctr #(.DEPTH(DEPTH)) u_rd_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clr     (fifo.flush_i),
    .inc     (rd_inc),
    .count   (rd_addr)
  );

  // Storage is deliberately not reset; an empty FIFO never exposes it.
  always_ff @(posedge clk_i) begin
    if (!reset_i && wr_inc) begin
      mem[wr_addr] <= fifo.wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i || fifo.flush_i) begin
      level <= '0;
    end else begin
      case ({wr_inc, rd_inc})
        2'b10:   level <= level + LVL_WIDTH'(1);
        2'b01:   level <= level - LVL_WIDTH'(1);
        default: level <= level;
      endcase
    end
  end

  // A new error event beats a coincident clear; flush freezes the flags.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (!fifo.flush_i) begin
      overflow  <= (fifo.wr_en_i && full)  || (overflow  && !fifo.clear_err_i);
      underflow <= (fifo.rd_en_i && empty) || (underflow && !fifo.clear_err_i);
    end
  end

  always_comb begin
    fifo.wfull_o         = full;
    fifo.rempty_o        = empty;
    fifo.level_o         = level;
    fifo.rdata_o         = mem[rd_addr];
    fifo.walmost_full_o  = (level >= fifo.afull_thresh_i);
    fifo.ralmost_empty_o = (level <= fifo.aempty_thresh_i);
    fifo.overflow_o      = overflow;
    fifo.underflow_o     = underflow;
  end

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Self-checking bench for sync_fifo_lvl at DEPTH=5: directed scenarios with
// literal expectations, then random traffic compared against a queue model.
module tb_sync_fifo_lvl;

  localparam int DW    = 16;
  localparam int DEPTH = 5;
  localparam int LW    = 3;

  logic clk_i;
  logic reset_i;

  sync_fifo_lvl_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fi ();

  sync_fifo_lvl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .fifo    (fi.slave)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_q [$];
  logic          model_ovf;
  logic          model_udf;
  logic          model_valid = 1'b0;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Reference behaviour expressed as queue operations on the pre-edge state.
  always @(posedge clk_i) begin
    if (reset_i) begin
      model_q.delete();
      model_ovf   = 1'b0;
      model_udf   = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (fi.flush_i) begin
        model_q.delete();
      end else begin
        automatic bit was_full  = (model_q.size() == DEPTH);
        automatic bit was_empty = (model_q.size() == 0);
        model_ovf = (fi.wr_en_i && was_full)  || (model_ovf && !fi.clear_err_i);
        model_udf = (fi.rd_en_i && was_empty) || (model_udf && !fi.clear_err_i);
        if (fi.rd_en_i && !was_empty) void'(model_q.pop_front());
        if (fi.wr_en_i && !was_full)  model_q.push_back(fi.wdata_i);
      end
    end
  end

  always @(negedge clk_i) begin
    if (model_valid) begin
      checkOutput("level", 32'(fi.level_o), 32'(model_q.size()));
      checkOutput("wfull", 32'(fi.wfull_o), 32'(model_q.size() == DEPTH));
      checkOutput("rempty", 32'(fi.rempty_o), 32'(model_q.size() == 0));
      checkOutput("walmost_full", 32'(fi.walmost_full_o),
                  32'(model_q.size() >= int'(fi.afull_thresh_i)));
      checkOutput("ralmost_empty", 32'(fi.ralmost_empty_o),
                  32'(model_q.size() <= int'(fi.aempty_thresh_i)));
      checkOutput("overflow", 32'(fi.overflow_o), 32'(model_ovf));
      checkOutput("underflow", 32'(fi.underflow_o), 32'(model_udf));
      if (model_q.size() > 0) begin
        checkOutput("rdata", 32'(fi.rdata_o), 32'(model_q[0]));
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] wd,
                               input logic rd, input logic fl, input logic clr);
    fi.wr_en_i     = wr;
    fi.wdata_i     = wd;
    fi.rd_en_i     = rd;
    fi.flush_i     = fl;
    fi.clear_err_i = clr;
    @(posedge clk_i);
    #1;
    fi.wr_en_i     = 1'b0;
    fi.rd_en_i     = 1'b0;
    fi.flush_i     = 1'b0;
    fi.clear_err_i = 1'b0;
  endtask

  task automatic pulseReset();
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic readExpect(input logic [DW-1:0] exp);
    checkOutput("pop_data", 32'(fi.rdata_o), 32'(exp));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic checkPostReset();
    checkOutput("rst_level", 32'(fi.level_o), 32'd0);
    checkOutput("rst_wfull", 32'(fi.wfull_o), 32'd0);
    checkOutput("rst_rempty", 32'(fi.rempty_o), 32'd1);
    checkOutput("rst_ralmost_empty", 32'(fi.ralmost_empty_o), 32'd1);
    checkOutput("rst_walmost_full", 32'(fi.walmost_full_o), 32'd0);
    checkOutput("rst_overflow", 32'(fi.overflow_o), 32'd0);
    checkOutput("rst_underflow", 32'(fi.underflow_o), 32'd0);
  endtask

  initial begin
    reset_i            = 1'b1;
    fi.wr_en_i         = 1'b0;
    fi.rd_en_i         = 1'b0;
    fi.flush_i         = 1'b0;
    fi.clear_err_i     = 1'b0;
    fi.wdata_i         = '0;
    fi.afull_thresh_i  = LW'(4);
    fi.aempty_thresh_i = LW'(1);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    checkPostReset();

    // Fill, overflow, drain.
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, DW'(16'hA0 + i), 1'b0, 1'b0, 1'b0);
      checkOutput("fill_level", 32'(fi.level_o), 32'(i + 1));
      if (i == 0) checkOutput("aempty_at_1", 32'(fi.ralmost_empty_o), 32'd1);
      if (i == 1) checkOutput("aempty_at_2", 32'(fi.ralmost_empty_o), 32'd0);
      if (i == 2) checkOutput("afull_at_3", 32'(fi.walmost_full_o), 32'd0);
      if (i == 3) checkOutput("afull_at_4", 32'(fi.walmost_full_o), 32'd1);
    end
    checkOutput("full_after_5", 32'(fi.wfull_o), 32'd1);
    applyStimulus(1'b1, 16'hFF, 1'b0, 1'b0, 1'b0);
    checkOutput("ovf_on_full_write", 32'(fi.overflow_o), 32'd1);
    checkOutput("level_after_drop", 32'(fi.level_o), 32'd5);
    for (int i = 0; i < DEPTH; i++) readExpect(DW'(16'hA0 + i));
    checkOutput("empty_after_drain", 32'(fi.rempty_o), 32'd1);

    // Address wrap.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(16'hC0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) readExpect(DW'(16'hC0 + i));
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(16'hB0 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) readExpect(DW'(16'hB0 + i));
    checkOutput("wrap_level_zero", 32'(fi.level_o), 32'd0);

    // Simultaneous read/write at level 2, 0 and 5.
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ovf_cleared", 32'(fi.overflow_o), 32'd0);
    applyStimulus(1'b1, 16'hD0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hD1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hD2, 1'b1, 1'b0, 1'b0);
    checkOutput("rw_at_2_level", 32'(fi.level_o), 32'd2);
    readExpect(16'hD1);
    readExpect(16'hD2);
    applyStimulus(1'b1, 16'hE0, 1'b1, 1'b0, 1'b0);
    checkOutput("rw_at_0_level", 32'(fi.level_o), 32'd1);
    checkOutput("rw_at_0_udf", 32'(fi.underflow_o), 32'd1);
    checkOutput("rw_at_0_data", 32'(fi.rdata_o), 32'h00E0);
    for (int i = 1; i < DEPTH; i++) applyStimulus(1'b1, DW'(16'hE0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hEE, 1'b1, 1'b0, 1'b0);
    checkOutput("rw_at_5_level", 32'(fi.level_o), 32'd4);
    checkOutput("rw_at_5_ovf", 32'(fi.overflow_o), 32'd1);
    checkOutput("rw_at_5_head", 32'(fi.rdata_o), 32'h00E1);

    // Clear coincident with a new overflow: set wins.
    applyStimulus(1'b1, 16'hE5, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'hEF, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_vs_set_ovf", 32'(fi.overflow_o), 32'd1);
    checkOutput("clr_vs_set_udf", 32'(fi.underflow_o), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_alone_ovf", 32'(fi.overflow_o), 32'd0);

    // Flush with a coincident write keeps error flags.
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(16'hF0 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h55, 1'b0, 1'b1, 1'b0);
    checkOutput("flush_level", 32'(fi.level_o), 32'd0);
    checkOutput("flush_rempty", 32'(fi.rempty_o), 32'd1);
    checkOutput("flush_keeps_udf", 32'(fi.underflow_o), 32'd1);

    // Reset mid-operation at level 4.
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(16'h70 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("pre_reset_level", 32'(fi.level_o), 32'd4);
    pulseReset();
    checkPostReset();

    // Randomised traffic with drifting read/write bias.
    begin
      int wr_bias = 50;
      int rd_bias = 50;
      for (int n = 0; n < 3000; n++) begin
        if (n % 200 == 0) begin
          fi.afull_thresh_i  = LW'($urandom_range(0, 7));
          fi.aempty_thresh_i = LW'($urandom_range(0, 7));
          wr_bias = $urandom_range(10, 90);
          rd_bias = $urandom_range(10, 90);
        end
        reset_i        = ($urandom_range(0, 299) == 0);
        fi.flush_i     = ($urandom_range(0, 79) == 0);
        fi.clear_err_i = ($urandom_range(0, 24) == 0);
        fi.wr_en_i     = ($urandom_range(0, 99) < wr_bias);
        fi.rd_en_i     = ($urandom_range(0, 99) < rd_bias);
        fi.wdata_i     = DW'($urandom);
        @(posedge clk_i);
        #1;
      end
      reset_i        = 1'b0;
      fi.flush_i     = 1'b0;
      fi.clear_err_i = 1'b0;
      fi.wr_en_i     = 1'b0;
      fi.rd_en_i     = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_fifo_lvl.md
Name: sync_fifo_lvl

Overview:
- Single-clock FIFO and parametrised successor of the basic synchronous FIFO.
- Adds arbitrary (non-power-of-2) depth, an exact fill-level output, runtime-programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags.
- Used in NoC/DTU buffering paths where credit logic needs the occupancy count and early back-pressure.
- Show-ahead read: rdata_o presents the head entry whenever rempty_o=0.

Parameters:
- DATA_WIDTH, 16, entry width in bits.
- DEPTH, 12, number of entries; any integer >= 2.
- LVL_WIDTH, $clog2(DEPTH+1), width of level and threshold ports; derived, not to be overridden.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- flush_i  in  1  synchronous clear of contents.
- wr_en_i  in  1  write request.
- wdata_i  in  DATA_WIDTH  write data.
- wfull_o  out  1  FIFO full; a write this cycle is dropped.
- walmost_full_o  out  1  level >= afull_thresh_i.
- rd_en_i  in  1  read/pop request.
- rdata_o  out  DATA_WIDTH  head entry; valid only when rempty_o=0.
- rempty_o  out  1  FIFO empty; a read this cycle is ignored.
- ralmost_empty_o  out  1  level <= aempty_thresh_i.
- afull_thresh_i  in  LVL_WIDTH  almost-full threshold (quasi-static).
- aempty_thresh_i  in  LVL_WIDTH  almost-empty threshold (quasi-static).
- level_o  out  LVL_WIDTH  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: a write was attempted while full.
- underflow_o  out  1  sticky: a read was attempted while empty.
- clear_err_i  in  1  clears overflow_o and underflow_o.

Behaviour:
- State: wr_addr and rd_addr (0..DEPTH-1), level register (0..DEPTH), error flags.
  - Each address wraps DEPTH-1 -> 0; no power-of-2 aliasing.
  - Memory is not reset.
- Accept conditions, both evaluated on registered state at cycle start:
  - wr_acc = wr_en_i & !wfull_o.
  - rd_acc = rd_en_i & !rempty_o.
- Decoded flags:
  - wfull_o = (level == DEPTH).
  - rempty_o = (level == 0).
  - Both are combinational from the level register only; no same-cycle bypass.
- Per-cycle update, in priority order:
  - reset_i: addresses=0, level=0, overflow_o=0, underflow_o=0.
  - Else flush_i: addresses=0, level=0; wr_en_i/rd_en_i ignored this cycle; error flags unchanged.
  - Else:
    - wr_acc: mem[wr_addr] <= wdata_i; wr_addr advances.
    - rd_acc: rd_addr advances.
    - level += wr_acc - rd_acc (a simultaneous accept leaves level unchanged).
- Full plus simultaneous read: the read is accepted and the write is dropped and flagged as overflow. Space frees only on the next cycle.
- Empty plus simultaneous write: the write is accepted and the read is ignored and flagged as underflow. Data becomes visible the next cycle (write-to-rempty_o-low latency 1 cycle).
- rdata_o = mem[rd_addr], combinational. Don't-care while rempty_o=1.
- Error flags:
  - overflow_o is set the cycle after wr_en_i & wfull_o; underflow_o likewise for rd_en_i & rempty_o.
  - clear_err_i clears both. A clear and a set in the same cycle: set wins.
  - Flags are not set while flush_i=1.
- Almost flags:
  - Combinational compares of the level register with the threshold ports.
  - afull_thresh_i=0 forces walmost_full_o=1.
  - aempty_thresh_i >= DEPTH forces ralmost_empty_o=1.
- Values after reset: level_o=0, wfull_o=0, rempty_o=1, ralmost_empty_o=1, walmost_full_o=(afull_thresh_i==0), overflow_o=0, underflow_o=0.
- Reset mid-operation: contents are discarded exactly as for flush; stale memory data is never observable because rempty_o=1.

Decomposition:
- Package sync_fifo_pkg holds the clog2 helper function and the level-width derivation.
- Sub-module sync_fifo_wrap_ctr: a modulo-DEPTH address counter with inc and clr inputs, instantiated twice (write and read).
- Memory array, level register, flags and error logic live in the top module.

Test Plan:
- DEPTH=5, reset then 5 writes 0xA0..0xA4 -> level_o goes 1..5, wfull_o=1 after the 5th; a 6th write of 0xFF is dropped and overflow_o=1 next cycle; 5 reads return 0xA0..0xA4 in order.
- Wrap-around with DEPTH=5: 3 writes, 3 reads, then 4 writes 0xB0..0xB3 -> write address wraps 4->0; reads return 0xB0..0xB3; level_o returns to 0.
- Simultaneous rd/wr at level 2 -> level_o stays 2, order preserved. At level 5 -> read accepted, level 4, overflow_o=1. At level 0 -> write accepted, level 1, underflow_o=1.
- Thresholds afull=4, aempty=1 -> walmost_full_o rises when level_o reaches 4; ralmost_empty_o=1 at levels 0 and 1 and 0 at level 2.
- At level 3, assert flush_i together with wr_en_i -> next cycle level_o=0, rempty_o=1, write discarded, error flags unchanged.
- Error flags set, then clear_err_i coincident with a new overflow -> overflow_o stays 1; clear_err_i alone -> both flags 0. reset_i at level 4 -> all outputs at their post-reset values.
